// File: rtl/bfly_pkg.sv
// Shared types and constants for the 256-bit inverse-butterfly permutation controller.
package bfly_pkg;

  localparam int BFLY_W      = 256;
  localparam int BFLY_STAGES = 8;
  localparam int BFLY_CFG_W  = 128;
  localparam int BFLY_WORDS  = 32;

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    RUN   = 2'd1,
    SWAP  = 2'd2
  } bfly_state_e;

  typedef logic [BFLY_STAGES-1:0][BFLY_CFG_W-1:0] bfly_bank_t;

  // Lower bit position of switch 'pair' in stage 'stage'; its partner sits 2**stage above.
  function automatic logic [7:0] bfly_pair_lo(input int stage, input int pair);
    return 8'(((pair >> stage) << (stage + 1)) | (pair & ((1 << stage) - 1)));
  endfunction

endpackage

// File: rtl/bfly_perm_ctrl_256_net.sv
// ibutterfly_net_256: combinational 8-stage inverse butterfly; stage k swaps bit pairs 2**k apart.
module ibutterfly_net_256
  import bfly_pkg::*;
(
  input  logic [BFLY_CFG_W-1:0] cfg0,
  input  logic [BFLY_CFG_W-1:0] cfg1,
  input  logic [BFLY_CFG_W-1:0] cfg2,
  input  logic [BFLY_CFG_W-1:0] cfg3,
  input  logic [BFLY_CFG_W-1:0] cfg4,
  input  logic [BFLY_CFG_W-1:0] cfg5,
  input  logic [BFLY_CFG_W-1:0] cfg6,
  input  logic [BFLY_CFG_W-1:0] cfg7,
  input  logic [BFLY_W-1:0]     data_i,
  output logic [BFLY_W-1:0]     data_o
);

  bfly_bank_t        cfg;
  logic [BFLY_W-1:0] stage_v;
  logic [BFLY_W-1:0] stage_n;
  logic [7:0]        lo;
  logic [7:0]        hi;

  assign cfg = {cfg7, cfg6, cfg5, cfg4, cfg3, cfg2, cfg1, cfg0};

  always_comb begin
    stage_v = data_i;
    stage_n = data_i;
    lo      = 8'd0;
    hi      = 8'd0;
    for (int k = 0; k < BFLY_STAGES; k++) begin
      stage_n = stage_v;
      for (int j = 0; j < BFLY_CFG_W; j++) begin
        lo = bfly_pair_lo(k, j);
        hi = lo + 8'(1 << k);
        if (cfg[3'(k)][7'(j)]) begin
          stage_n[lo] = stage_v[hi];
          stage_n[hi] = stage_v[lo];
        end
      end
      stage_v = stage_n;
    end
    data_o = stage_v;
  end

endmodule

// File: rtl/bfly_perm_ctrl_256.sv
// Double-banked configuration and 1-deep output pipeline around ibutterfly_net_256.
// Optional BFLY_CNT_EN adds the saturating perm_cnt completed-transfer counter.
module bfly_perm_ctrl_256
  import bfly_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [4:0]        cfg_addr,
  input  logic [31:0]       cfg_wdata,
  input  logic              cfg_commit,
  output logic              cfg_err,
  output logic              cfg_active,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BFLY_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BFLY_W-1:0] out_data,
  output bfly_state_e       dbg_state
`ifdef BFLY_CNT_EN
  ,
  output logic [15:0]       perm_cnt
`endif
);

  bfly_state_e       state_q, state_d;
  logic [31:0]       mask_q, mask_d;
  bfly_bank_t        shadow_q, shadow_d;
  bfly_bank_t        active_q, active_d;
  logic              out_valid_q, out_valid_d;
  logic [BFLY_W-1:0] out_data_q, out_data_d;
  logic              cfg_err_q, cfg_err_d;
  logic              cfg_active_q, cfg_active_d;
  logic [BFLY_W-1:0] net_out;
  logic              accept;
  logic              drain;

  ibutterfly_net_256 u_net (
    .cfg0   (active_q[0]),
    .cfg1   (active_q[1]),
    .cfg2   (active_q[2]),
    .cfg3   (active_q[3]),
    .cfg4   (active_q[4]),
    .cfg5   (active_q[5]),
    .cfg6   (active_q[6]),
    .cfg7   (active_q[7]),
    .data_i (in_data),
    .data_o (net_out)
  );

  // Valid/ready: a word moves when valid && ready on a rising edge; valid never drops and
  // data never changes while the consumer withholds ready. Input stalls during commit/SWAP.
  assign in_ready = (state_q == RUN) && !cfg_commit && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid_q && out_ready;

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    shadow_d     = shadow_q;
    active_d     = active_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    cfg_err_d    = 1'b0;
    cfg_active_d = cfg_active_q;

    case (state_q)
      UNCFG, RUN: begin
        if (cfg_commit) begin
          if (&mask_q) state_d   = SWAP;
          else         cfg_err_d = 1'b1;
        end
      end
      SWAP: begin
        active_d     = shadow_q;
        mask_d       = '0;
        cfg_active_d = 1'b1;
        state_d      = RUN;
      end
      default: state_d = UNCFG;
    endcase

    // Applied after the commit decision so a same-cycle write is tracked in the fresh mask.
    if (cfg_we) begin
      shadow_d[cfg_addr[4:2]][{cfg_addr[1:0], 5'd0} +: 32] = cfg_wdata;
      mask_d[cfg_addr] = 1'b1;
    end

    if (accept) begin
      out_data_d  = net_out;
      out_valid_d = 1'b1;
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= UNCFG;
      mask_q       <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      cfg_err_q    <= 1'b0;
      cfg_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      cfg_err_q    <= cfg_err_d;
      cfg_active_q <= cfg_active_d;
    end
  end

  assign cfg_err    = cfg_err_q;
  assign cfg_active = cfg_active_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign dbg_state  = state_q;

`ifdef BFLY_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == SWAP)                cnt_d = '0;
    else if (drain && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign perm_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_bfly_perm_ctrl_256.sv
// Self-checking bench for bfly_perm_ctrl_256 against a word-level behavioural model.
module tb_bfly_perm_ctrl_256;
  import bfly_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_we = 1'b0;
  logic [4:0]   cfg_addr = '0;
  logic [31:0]  cfg_wdata = '0;
  logic         cfg_commit = 1'b0;
  logic         cfg_err, cfg_active;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [255:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [255:0] out_data;
  bfly_state_e  dbg_state;
`ifdef BFLY_CNT_EN
  logic [15:0]  perm_cnt;
`endif

  bfly_perm_ctrl_256 dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_commit(cfg_commit), .cfg_err(cfg_err), .cfg_active(cfg_active),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .dbg_state(dbg_state)
`ifdef BFLY_CNT_EN
    , .perm_cnt(perm_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit rand_traffic = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [1023:0] m_shadow, m_active;
  bit   [31:0]   m_written;
  bit            m_in_swap, m_cfg_active, m_err;
  int            m_cnt;
  logic [255:0]  exp_q[$];

  function automatic logic [255:0] model_perm(input logic [255:0] d, input logic [1023:0] bank);
    logic [255:0] v;
    logic         t;
    int           j, q;
    v = d;
    for (int k = 0; k < 8; k++)
      for (int p = 0; p < 256; p++)
        if (((p >> k) & 1) == 0) begin
          j = ((p >> (k + 1)) << k) | (p & ((1 << k) - 1));
          q = p + (1 << k);
          if (bank[10'(k * 128 + j)]) begin
            t = v[8'(p)];
            v[8'(p)] = v[8'(q)];
            v[8'(q)] = t;
          end
        end
    return v;
  endfunction

  function automatic bit model_rdy();
    return m_cfg_active && !m_in_swap && !cfg_commit && (exp_q.size() == 0 || out_ready);
  endfunction

  function automatic bfly_state_e exp_state();
    if (m_in_swap) return SWAP;
    if (m_cfg_active) return RUN;
    return UNCFG;
  endfunction

  task automatic model_reset();
    m_shadow = '0; m_active = '0; m_written = '0;
    m_in_swap = 0; m_cfg_active = 0; m_err = 0; m_cnt = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit rdy, pop, acc, was_swap;
    logic [255:0] res;
    rdy = model_rdy();
    pop = (exp_q.size() != 0) && out_ready;
    acc = in_valid && rdy;
    res = acc ? model_perm(in_data, m_active) : '0;
    was_swap = m_in_swap;
    m_err = 0;
    if (was_swap) begin
      m_active = m_shadow; m_written = '0; m_cfg_active = 1; m_in_swap = 0; m_cnt = 0;
    end else if (cfg_commit) begin
      if (&m_written) m_in_swap = 1;
      else            m_err = 1;
    end
    if (cfg_we) begin
      m_shadow[{cfg_addr, 5'd0} +: 32] = cfg_wdata;
      m_written[cfg_addr] = 1;
    end
    if (pop) begin
      void'(exp_q.pop_front());
      if (!was_swap && m_cnt < 65535) m_cnt++;
    end
    if (acc) exp_q.push_back(res);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // Per-cycle compare against the model.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      check("in_ready", 256'(in_ready), 256'(model_rdy()));
      check("out_valid", 256'(out_valid), 256'(exp_q.size() != 0));
      if (exp_q.size() != 0) check("out_data", out_data, exp_q[0]);
      check("cfg_err", 256'(cfg_err), 256'(m_err));
      check("cfg_active", 256'(cfg_active), 256'(m_cfg_active));
      check("state", 256'(dbg_state), 256'(exp_state()));
`ifdef BFLY_CNT_EN
      check("perm_cnt", 256'(perm_cnt), 256'(m_cnt));
`endif
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r = '0;
    for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom)};
    return r;
  endfunction

  function automatic logic [1023:0] rand1024();
    logic [1023:0] r = '0;
    for (int i = 0; i < 32; i++) r = {r[991:0], 32'($urandom)};
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_traffic) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = rand256();
    end
  end

  task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic load_bank(input logic [1023:0] b);
    logic [1023:0] bb = b;
    for (int i = 0; i < 32; i++) begin
      cfg_write(5'(i), bb[31:0]);
      bb = bb >> 32;
    end
  endtask

  task automatic do_commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic wait_run();
    int n = 0;
    while (!(cfg_active && dbg_state == RUN) && n < 10) begin
      tick();
      n++;
    end
    check("wait_run_timeout", 256'(n < 10), 256'(1));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1023:0] bank;
    logic [255:0]  d0, exp_hold;
    int errs, rdys, accs;
    bit last_commit;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", 256'(out_valid), 256'(0));
    check("rst_out_data", out_data, 256'(0));
    check("rst_cfg_err", 256'(cfg_err), 256'(0));
    check("rst_cfg_active", 256'(cfg_active), 256'(0));
    check("rst_in_ready", 256'(in_ready), 256'(0));
    check("rst_state", 256'(dbg_state), 256'(UNCFG));
    tick();
    rst_n = 1'b1;
    tick();

    // Partial mask commit is rejected
    for (int i = 0; i < 31; i++) cfg_write(5'(i), 32'd0);
    in_valid = 1'b1; out_ready = 1'b1;
    do_commit();
    errs = 0; rdys = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (cfg_err) errs++;
      if (in_ready) rdys++;
      tick();
    end
    check("partial_err_pulses", 256'(errs), 256'(1));
    check("partial_state", 256'(dbg_state), 256'(UNCFG));
    check("partial_in_ready_seen", 256'(rdys), 256'(0));
    in_valid = 1'b0;

    // Identity configuration
    cfg_write(5'd31, 32'd0);
    do_commit();
    wait_run();
    check("ident_cfg_active", 256'(cfg_active), 256'(1));
    in_valid = 1'b1; in_data = 256'h123;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("ident_out_valid", 256'(out_valid), 256'(1));
    check("ident_out_data", out_data, 256'h123);
    tick();

    // Stage 0 all-ones swaps adjacent bits
    bank = '0;
    bank[127:0] = '1;
    load_bank(bank);
    do_commit();
    wait_run();
    in_valid = 1'b1; in_data = 256'h1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("stage0_out_data", out_data, 256'h2);
    check("model_pin_stage0", model_perm(256'h55, bank), 256'hAA);
    tick();

    // Backpressure: exactly one word accepted, held stable, then full rate
    out_ready = 1'b0; in_valid = 1'b1;
    d0 = rand256(); in_data = d0;
    exp_hold = model_perm(d0, bank);
    accs = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (in_valid && in_ready) accs++;
      if (i > 0) begin
        check("stall_hold_data", out_data, exp_hold);
        check("stall_in_ready", 256'(in_ready), 256'(0));
      end
      tick();
      in_data = rand256();
    end
    check("stall_accepts", 256'(accs), 256'(1));
    out_ready = 1'b1;
    accs = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (in_valid && in_ready) accs++;
      tick();
      in_data = rand256();
    end
    check("stream_rate", 256'(accs), 256'(8));
    in_valid = 1'b0;
    tick();

    // Commit while a word is held: held word keeps old-bank result
    out_ready = 1'b0; in_valid = 1'b1; in_data = 256'h55;
    tick();
    in_valid = 1'b0;
    load_bank('0);
    cfg_commit = 1'b1;
    @(negedge clk);
    check("commit_in_ready", 256'(in_ready), 256'(0));
    check("commit_hold", out_data, 256'hAA);
    tick();
    cfg_commit = 1'b0;
    @(negedge clk);
    check("swap_state", 256'(dbg_state), 256'(SWAP));
    check("swap_in_ready", 256'(in_ready), 256'(0));
    check("swap_hold", out_data, 256'hAA);
    tick();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 256'h55;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("newbank_out_data", out_data, 256'h55);
    tick();

    // Randomized traffic with random configuration activity
    rand_traffic = 1'b1;
    load_bank(rand1024());
    do_commit();
    last_commit = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (last_commit) begin
        cfg_we = 1'b0; cfg_commit = 1'b0; last_commit = 1'b0;
      end else begin
        cfg_we     = ($urandom_range(0, 1) == 1);
        cfg_addr   = 5'($urandom_range(0, 31));
        cfg_wdata  = $urandom;
        cfg_commit = ($urandom_range(0, 15) == 0);
        last_commit = cfg_commit;
      end
      tick();
    end
    cfg_we = 1'b0; cfg_commit = 1'b0;
    rand_traffic = 1'b0;
    tick();

    // Reset mid-transfer discards the held word
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();
    out_ready = 1'b0; in_valid = 1'b1; in_data = rand256();
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_held", 256'(out_valid), 256'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 256'(out_valid), 256'(0));
    check("midrst_out_data", out_data, 256'(0));
    check("midrst_cfg_active", 256'(cfg_active), 256'(0));
    tick();
    tick();
    rst_n = 1'b1;
    tick();

`ifdef BFLY_CNT_EN
    load_bank(rand1024());
    do_commit();
    wait_run();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      in_data = {224'd0, 32'(i)};
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("cnt_saturated", 256'(perm_cnt), 256'(16'hFFFF));
    load_bank('0);
    do_commit();
    tick();
    @(negedge clk);
    check("cnt_cleared", 256'(perm_cnt), 256'(0));
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
